// File: rtl/csa_accum_resolve_if.sv
// csa_accum_resolve_if
//   Stream bundle for the carry-save accumulator: an input beat channel
//   (in_*) and a result channel (out_*).
//
//   Handshake rule for both channels: a transfer happens on a rising clk
//   edge where valid and ready are both high. A source holds its payload
//   stable until that edge. Ready never depends on valid in the same cycle.
//
//   Modports:
//     master - producer of beats / consumer of results (testbench side)
//     slave  - the accumulator itself
interface csa_accum_resolve_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_wrap;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_wrap
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_wrap
  );
endinterface

// File: rtl/csa_accum_resolve.sv
// csa_accum_resolve
//   Streaming accumulator. Each input beat is folded into a redundant
//   (sum, carry) pair with a single 3:2 carry-save stage. On the final beat
//   of a burst the pair is resolved into a binary word by a CW-bit
//   carry-propagate adder, one chunk per cycle (NCH = DW/CW cycles).
//
//   Ports:
//     clk       - rising-edge clock
//     nreset    - asynchronous active-low reset
//     bus       - slave side of csa_accum_resolve_if
//                 (in_valid/in_ready/in_data/in_last,
//                  out_valid/out_ready/out_data/out_wrap)
//     busy      - high unless idle in ACCUM with an all-zero accumulator
//     dbg_state - current FSM state (0=ACCUM, 1=RESOLVE, 2=OUTPUT)
module csa_accum_resolve #(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  csa_accum_resolve_if.slave   bus,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int NCH = DW / CW;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] s_reg;
  logic [DW-1:0] c_reg;
  logic          wrap;
  logic [IW-1:0] idx;
  logic          cin;
  logic [DW-1:0] out_data_r;

  logic          in_ready_c;
  logic          out_valid_c;
  logic          in_fire;
  logic          out_fire;
  logic          last_chunk;
  logic [DW-1:0] maj;
  logic [CW-1:0] s_chunk;
  logic [CW-1:0] c_chunk;
  logic [CW:0]   chunk_sum;

  // Carry-save compression of (s_reg, c_reg, in_data).
  assign maj = (s_reg & c_reg) | (s_reg & bus.in_data) | (c_reg & bus.in_data);

  // One slice of the carry-propagate adder; chunk_sum[CW] is the chunk carry.
  assign s_chunk    = s_reg[idx*CW +: CW];
  assign c_chunk    = c_reg[idx*CW +: CW];
  assign chunk_sum  = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CW{1'b0}}, cin};
  assign last_chunk = (idx == IW'(NCH - 1));

  assign in_fire  = in_ready_c & bus.in_valid;
  assign out_fire = out_valid_c & bus.out_ready;

  // Next-state and handshake outputs.
  always_comb begin
    next_state  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && bus.in_last) next_state = RESOLVE;
      end
      RESOLVE: begin
        if (last_chunk) next_state = OUTPUT;
      end
      OUTPUT: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) next_state = ACCUM;
      end
      default: next_state = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ACCUM;
    else         state <= next_state;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s_reg      <= '0;
      c_reg      <= '0;
      wrap       <= 1'b0;
      idx        <= '0;
      cin        <= 1'b0;
      out_data_r <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_fire) begin
            s_reg <= s_reg ^ c_reg ^ bus.in_data;
            // The shifted-out MSB carry is a lost 2^DW: record it as wrap.
            c_reg <= {maj[DW-2:0], 1'b0};
            wrap  <= wrap | maj[DW-1];
            if (bus.in_last) begin
              idx <= '0;
              cin <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          out_data_r[idx*CW +: CW] <= chunk_sum[CW-1:0];
          cin <= chunk_sum[CW];
          if (last_chunk) begin
            wrap <= wrap | chunk_sum[CW];
            idx  <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            s_reg <= '0;
            c_reg <= '0;
            wrap  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = out_data_r;
  assign bus.out_wrap  = wrap & out_valid_c;

  assign busy      = (state != ACCUM) | (|s_reg) | (|c_reg) | wrap;
  assign dbg_state = state;

endmodule

// File: tb/tb_csa_accum_resolve.sv
// tb_csa_accum_resolve
//   Bench for csa_accum_resolve: directed bursts (basic, cross-chunk carry,
//   overflow, backpressure, asynchronous reset) followed by a randomized
//   regression. Expected results come from a 64-bit running sum.
module tb_csa_accum_resolve;
  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int NCH = DW / CW;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       busy;
  logic [1:0] dbg_state;

  csa_accum_resolve_if #(.DW(DW)) bus ();

  csa_accum_resolve #(.DW(DW), .CW(CW)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0]  exp_q[$];   // {wrap, data}
  logic [63:0]  acc;        // model: exact burst sum
  int           n_checks = 0;
  int           n_fail   = 0;
  int           ready_pct = 100;
  int           gap_pct   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [DW:0] e;
    if (nreset && bus.out_valid && bus.out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got data 0x%0h wrap %0b, expected none", bus.out_data, bus.out_wrap);
      end else begin
        n_checks--;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e[DW-1:0]);
        check("out_wrap", bus.out_wrap, e[DW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    int n;
    if (gap_pct > 0) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    acc = acc + 64'(d);
    if (last) begin
      exp_q.push_back({(acc >= (64'd1 << DW)), acc[DW-1:0]});
      acc = '0;
    end
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_handshake_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int k;
    int len;
    logic [DW-1:0] d;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    acc = '0;

    // Reset values
    #12;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_wrap",  bus.out_wrap,  0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_busy",      busy,          0);
    check("rst_state",     dbg_state,     0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst with latency and backpressure checks
    ready_pct = 0;
    @(posedge clk);
    #1;
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      check("in_ready_resolve", bus.in_ready, 0);
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 64'(k), 64'(NCH));
    for (int i = 0; i < 10; i++) begin
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_out_data",  bus.out_data,  6);
      check("hold_out_wrap",  bus.out_wrap,  0);
      check("hold_in_ready",  bus.in_ready,  0);
      @(posedge clk);
      #1;
    end
    ready_pct = 100;
    wait_drain();
    check("post_out_in_ready", bus.in_ready, 1);
    check("post_out_busy",     busy,         0);

    // Accumulator cleared after a held result
    send_beat(32'd5, 1'b1);
    wait_drain();

    // Cross-chunk carry
    send_beat(32'h00FF_FFFF, 1'b0);
    send_beat(32'h0000_0001, 1'b1);
    wait_drain();

    // Overflow, held under backpressure, then released
    ready_pct = 0;
    @(posedge clk);
    #1;
    send_beat(32'hFFFF_FFFF, 1'b0);
    send_beat(32'h0000_0002, 1'b1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      check("ovf_hold_data",     bus.out_data, 1);
      check("ovf_hold_wrap",     bus.out_wrap, 1);
      check("ovf_hold_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    ready_pct = 100;
    wait_drain();

    // Dropped-MSB path
    send_beat(32'h8000_0000, 1'b0);
    send_beat(32'h8000_0000, 1'b1);
    wait_drain();

    // Asynchronous reset during RESOLVE chunk 2
    send_beat(32'h10, 1'b0);
    send_beat(32'h20, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_rst_state", dbg_state, 1);
    check("pre_rst_busy",  busy,      1);
    nreset = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_busy",      busy,          0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    exp_q.delete();
    acc = '0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    send_beat(32'd7, 1'b1);
    wait_drain();

    // Random regression
    ready_pct = 60;
    gap_pct   = 30;
    for (int b = 0; b < 1000; b++) begin
      len = $urandom_range(1, 16);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 3))
          0:       d = 32'hFFFF_FFFF - $urandom_range(0, 15);
          1:       d = $urandom_range(0, 255);
          default: d = $urandom;
        endcase
        send_beat(d, (j == len - 1));
      end
    end
    ready_pct = 100;
    gap_pct   = 0;
    wait_drain();
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
